// File: rtl/trigger_event_logger_pkg.sv
// ---------------------------------------------------------------------------
// trigger_pkg
// Shared definitions for the trigger event logger: the controller state
// encoding and the default widths used when the logger is instantiated
// without overrides.
// ---------------------------------------------------------------------------
package trigger_pkg;

    // Default widths: accepted/rejected counters, RAM address, timestamp.
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_ADDR_W = 15;
    localparam int DEF_TS_W   = 32;

    // Controller states, binary encoded.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FULL  = 2'd3
    } state_e;

endpackage

// File: rtl/trigger_event_logger_qualifier.sv
// ---------------------------------------------------------------------------
// trigger_qualifier
// Turns the raw trigger into a qualified event: either every high cycle
// (level mode) or only the first high cycle after a low one (edge mode).
// Ports:
//   clk_i      system clock
//   reset_i    asynchronous active-high reset
//   trigger_i  raw trigger
//   qual_o     qualified trigger, combinational from trigger_i
// ---------------------------------------------------------------------------
module trigger_qualifier #(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic trigger_i,
    output logic qual_o
);

    logic trigD_q;

    // The delayed copy of the trigger is updated on every cycle regardless of
    // the controller state, so arming the logger while the trigger is already
    // high never looks like a fresh rising edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            trigD_q <= 1'b0;
        end else begin
            trigD_q <= trigger_i;
        end
    end

    assign qual_o = EDGE_MODE ? (trigger_i & ~trigD_q) : trigger_i;

endmodule

// File: rtl/trigger_event_logger.sv
// ---------------------------------------------------------------------------
// trigger_event_logger
// Qualifies a trigger, applies a hold-off after every accepted event, keeps
// saturating accepted/rejected counts and writes one timestamp per accepted
// event into the simulation RAM.
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   enable_i                  arms the logger
//   clear_i                   synchronous clear of counts, pointer, flags, timestamp
//   trigger_i                 raw trigger
//   counter_o                 accepted-event count (saturating)
//   rej_counter_o             rejected-event count (saturating)
//   simu_ram_wr_req_o         one-cycle write strobe per accepted event
//   simu_ram_wr_addr_o        write address, first event at 0
//   simu_ram_wr_data_o        timestamp of the accepted event
//   full_o                    non-wrapping mode: every address written
//   wrapped_o                 wrapping mode: sticky, pointer wrapped
//   cnt_sat_o                 sticky: a counter reached all-ones
// ---------------------------------------------------------------------------
module trigger_event_logger
    import trigger_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int TS_W      = DEF_TS_W,
    parameter bit EDGE_MODE = 1'b1,
    parameter bit WRAP_MODE = 1'b0,
    parameter int HOLDOFF   = 0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic              clear_i,
    input  logic              trigger_i,
    output logic [CNT_W-1:0]  counter_o,
    output logic [CNT_W-1:0]  rej_counter_o,
    output logic              simu_ram_wr_req_o,
    output logic [ADDR_W-1:0] simu_ram_wr_addr_o,
    output logic [TS_W-1:0]   simu_ram_wr_data_o,
    output logic              full_o,
    output logic              wrapped_o,
    output logic              cnt_sat_o
);

    localparam int HCNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [HCNT_W-1:0] HOLD_LOAD = HCNT_W'(HOLDOFF);

    state_e            state_q;
    logic [CNT_W-1:0]  counter_q;
    logic [CNT_W-1:0]  rejCounter_q;
    logic [CNT_W-1:0]  counterInc_d;
    logic [CNT_W-1:0]  rejInc_d;
    logic [ADDR_W-1:0] wrPtr_q;
    logic [ADDR_W-1:0] wrAddr_q;
    logic [TS_W-1:0]   timestamp_q;
    logic [TS_W-1:0]   wrData_q;
    logic [HCNT_W-1:0] hcnt_q;
    logic              wrReq_q;
    logic              full_q;
    logic              wrapped_q;
    logic              cntSat_q;
    logic              qual;

    trigger_qualifier #(
        .EDGE_MODE (EDGE_MODE)
    ) uQualifier (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .trigger_i (trigger_i),
        .qual_o    (qual)
    );

    // Saturating next values for both counters: once a counter is all-ones it
    // simply stays there, there is no carry out.
    always_comb begin
        counterInc_d = (counter_q == CNT_MAX) ? counter_q : counter_q + CNT_W'(1);
        rejInc_d     = (rejCounter_q == CNT_MAX) ? rejCounter_q : rejCounter_q + CNT_W'(1);
    end

    // Controller, counters, pointer and RAM write port all live in one block so
    // every output is a register. Clear wins over any qualified trigger in the
    // same cycle. The write strobe defaults low and is raised only on accepts;
    // address/data keep their last value otherwise. In hold-off and full, a
    // qualified trigger is counted as rejected. Dropping enable aborts the
    // hold-off but keeps all counts and flags; the full state ignores enable.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            counter_q    <= '0;
            rejCounter_q <= '0;
            wrPtr_q      <= '0;
            wrAddr_q     <= '0;
            timestamp_q  <= '0;
            wrData_q     <= '0;
            hcnt_q       <= '0;
            wrReq_q      <= 1'b0;
            full_q       <= 1'b0;
            wrapped_q    <= 1'b0;
            cntSat_q     <= 1'b0;
        end else begin
            timestamp_q <= timestamp_q + TS_W'(1);
            wrReq_q     <= 1'b0;
            if (clear_i) begin
                timestamp_q  <= '0;
                counter_q    <= '0;
                rejCounter_q <= '0;
                wrPtr_q      <= '0;
                hcnt_q       <= '0;
                full_q       <= 1'b0;
                wrapped_q    <= 1'b0;
                cntSat_q     <= 1'b0;
                state_q      <= enable_i ? ST_ARMED : ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (enable_i) begin
                            state_q <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (!enable_i) begin
                            state_q <= ST_IDLE;
                        end else if (qual) begin
                            wrReq_q   <= 1'b1;
                            wrAddr_q  <= wrPtr_q;
                            wrData_q  <= timestamp_q;
                            counter_q <= counterInc_d;
                            if (counterInc_d == CNT_MAX) begin
                                cntSat_q <= 1'b1;
                            end
                            if ((wrPtr_q == LAST_ADDR) && !WRAP_MODE) begin
                                full_q  <= 1'b1;
                                state_q <= ST_FULL;
                            end else begin
                                wrPtr_q <= wrPtr_q + ADDR_W'(1);
                                if (wrPtr_q == LAST_ADDR) begin
                                    wrapped_q <= 1'b1;
                                end
                                if (HOLDOFF > 0) begin
                                    hcnt_q  <= HOLD_LOAD;
                                    state_q <= ST_HOLD;
                                end
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!enable_i) begin
                            hcnt_q  <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            hcnt_q <= hcnt_q - HCNT_W'(1);
                            if (qual) begin
                                rejCounter_q <= rejInc_d;
                                if (rejInc_d == CNT_MAX) begin
                                    cntSat_q <= 1'b1;
                                end
                            end
                            if (hcnt_q == HCNT_W'(1)) begin
                                state_q <= ST_ARMED;
                            end
                        end
                    end
                    ST_FULL: begin
                        if (qual) begin
                            rejCounter_q <= rejInc_d;
                            if (rejInc_d == CNT_MAX) begin
                                cntSat_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign counter_o          = counter_q;
    assign rej_counter_o      = rejCounter_q;
    assign simu_ram_wr_req_o  = wrReq_q;
    assign simu_ram_wr_addr_o = wrAddr_q;
    assign simu_ram_wr_data_o = wrData_q;
    assign full_o             = full_q;
    assign wrapped_o          = wrapped_q;
    assign cnt_sat_o          = cntSat_q;

endmodule

// File: tb/tb_trigger_event_logger.sv
// ---------------------------------------------------------------------------
// tb_trigger_event_logger
// Directed bench for the trigger event logger. Six instances with different
// parameter sets share clock, reset, enable and clear; each has its own
// trigger bit. Inputs change and outputs are sampled on the falling edge.
//   A: defaults (edge mode)       B: level mode
//   C: hold-off of 4              D: 4-entry RAM, stops when full
//   E: 4-entry RAM, wrapping      F: 3-bit counters, 16-entry RAM
// ---------------------------------------------------------------------------
module tb_trigger_event_logger;
    import trigger_pkg::*;

    localparam logic [5:0] TA = 6'b000001;
    localparam logic [5:0] TB = 6'b000010;
    localparam logic [5:0] TC = 6'b000100;
    localparam logic [5:0] TD = 6'b001000;
    localparam logic [5:0] TE = 6'b010000;
    localparam logic [5:0] TF = 6'b100000;
    localparam logic [5:0] TN = 6'b000000;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        clear;
    logic [5:0]  trig;

    logic [15:0] cntA, rejA, cntB, rejB, cntC, rejC, cntD, rejD, cntE, rejE;
    logic [2:0]  cntF, rejF;
    logic [14:0] addrA, addrB, addrC;
    logic [1:0]  addrD, addrE;
    logic [3:0]  addrF;
    logic [31:0] dataA, dataB, dataC, dataD, dataE, dataF;
    logic        reqA, reqB, reqC, reqD, reqE, reqF;
    logic        fullA, fullB, fullC, fullD, fullE, fullF;
    logic        wrapA, wrapB, wrapC, wrapD, wrapE, wrapF;
    logic        satA, satB, satC, satD, satE, satF;

    int passCount;
    int checkCount;
    int nA;
    int nB;
    logic [7:0] patC;

    trigger_event_logger dutA (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .clear_i(clear), .trigger_i(trig[0]),
        .counter_o(cntA), .rej_counter_o(rejA), .simu_ram_wr_req_o(reqA),
        .simu_ram_wr_addr_o(addrA), .simu_ram_wr_data_o(dataA),
        .full_o(fullA), .wrapped_o(wrapA), .cnt_sat_o(satA)
    );

    trigger_event_logger #(.EDGE_MODE(1'b0)) dutB (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .clear_i(clear), .trigger_i(trig[1]),
        .counter_o(cntB), .rej_counter_o(rejB), .simu_ram_wr_req_o(reqB),
        .simu_ram_wr_addr_o(addrB), .simu_ram_wr_data_o(dataB),
        .full_o(fullB), .wrapped_o(wrapB), .cnt_sat_o(satB)
    );

    trigger_event_logger #(.HOLDOFF(4)) dutC (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .clear_i(clear), .trigger_i(trig[2]),
        .counter_o(cntC), .rej_counter_o(rejC), .simu_ram_wr_req_o(reqC),
        .simu_ram_wr_addr_o(addrC), .simu_ram_wr_data_o(dataC),
        .full_o(fullC), .wrapped_o(wrapC), .cnt_sat_o(satC)
    );

    trigger_event_logger #(.ADDR_W(2), .WRAP_MODE(1'b0)) dutD (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .clear_i(clear), .trigger_i(trig[3]),
        .counter_o(cntD), .rej_counter_o(rejD), .simu_ram_wr_req_o(reqD),
        .simu_ram_wr_addr_o(addrD), .simu_ram_wr_data_o(dataD),
        .full_o(fullD), .wrapped_o(wrapD), .cnt_sat_o(satD)
    );

    trigger_event_logger #(.ADDR_W(2), .WRAP_MODE(1'b1)) dutE (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .clear_i(clear), .trigger_i(trig[4]),
        .counter_o(cntE), .rej_counter_o(rejE), .simu_ram_wr_req_o(reqE),
        .simu_ram_wr_addr_o(addrE), .simu_ram_wr_data_o(dataE),
        .full_o(fullE), .wrapped_o(wrapE), .cnt_sat_o(satE)
    );

    trigger_event_logger #(.CNT_W(3), .ADDR_W(4)) dutF (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .clear_i(clear), .trigger_i(trig[5]),
        .counter_o(cntF), .rej_counter_o(rejF), .simu_ram_wr_req_o(reqF),
        .simu_ram_wr_addr_o(addrF), .simu_ram_wr_data_o(dataF),
        .full_o(fullF), .wrapped_o(wrapF), .cnt_sat_o(satF)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle worth of inputs and move to the next falling edge, so
    // the outputs seen afterwards reflect the rising edge that used them.
    task automatic applyStimulus(input logic [5:0] trigVec, input logic clr, input logic en);
        trig   = trigVec;
        clear  = clr;
        enable = en;
        @(negedge clk);
    endtask

    // One comparison: counts it, and reports tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Directed sequence: reset, pulses, held trigger, idle, clear, hold-off,
    // full/wrap, saturation, reset in hold-off.
    initial begin
        passCount  = 0;
        checkCount = 0;
        reset      = 1'b1;
        enable     = 1'b0;
        clear      = 1'b0;
        trig       = TN;
        patC       = 8'b0010_0101;
        @(negedge clk);

        checkOutput("rst_cntA",  64'(cntA),  64'd0);
        checkOutput("rst_rejA",  64'(rejA),  64'd0);
        checkOutput("rst_reqA",  64'(reqA),  64'd0);
        checkOutput("rst_addrA", 64'(addrA), 64'd0);
        checkOutput("rst_dataA", 64'(dataA), 64'd0);
        checkOutput("rst_fullD", 64'(fullD), 64'd0);
        checkOutput("rst_wrapE", 64'(wrapE), 64'd0);
        checkOutput("rst_satF",  64'(satF),  64'd0);
        checkOutput("rst_stA",   64'(dutA.state_q), 64'(ST_IDLE));

        reset = 1'b0;
        applyStimulus(TN, 1'b0, 1'b1);
        checkOutput("arm_stA", 64'(dutA.state_q), 64'(ST_ARMED));

        // Three single-cycle pulses, accepts two cycles apart after a clear.
        applyStimulus(TN, 1'b1, 1'b1);
        for (int p = 0; p < 3; p++) begin
            applyStimulus(TA, 1'b0, 1'b1);
            checkOutput($sformatf("t1_req%0d", p),  64'(reqA),  64'd1);
            checkOutput($sformatf("t1_addr%0d", p), 64'(addrA), 64'(p));
            checkOutput($sformatf("t1_data%0d", p), 64'(dataA), 64'(2 * p));
            applyStimulus(TN, 1'b0, 1'b1);
            checkOutput($sformatf("t1_reqlo%0d", p), 64'(reqA), 64'd0);
        end
        checkOutput("t1_cnt", 64'(cntA), 64'd3);
        checkOutput("t1_rej", 64'(rejA), 64'd0);

        // Trigger held for ten cycles: edge mode writes once, level mode ten times.
        applyStimulus(TN, 1'b1, 1'b1);
        nA = 0;
        nB = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(TA | TB, 1'b0, 1'b1);
            nA += int'(reqA);
            nB += int'(reqB);
        end
        applyStimulus(TN, 1'b0, 1'b1);
        checkOutput("t2_writesA", 64'(nA),    64'd1);
        checkOutput("t2_writesB", 64'(nB),    64'd10);
        checkOutput("t2_cntA",    64'(cntA),  64'd1);
        checkOutput("t2_cntB",    64'(cntB),  64'd10);
        checkOutput("t2_addrB",   64'(addrB), 64'd9);
        checkOutput("t2_reqB",    64'(reqB),  64'd0);

        // Disabled: a pulse is ignored and counts are kept.
        applyStimulus(TN, 1'b0, 1'b0);
        applyStimulus(TA, 1'b0, 1'b0);
        checkOutput("idle_req", 64'(reqA), 64'd0);
        applyStimulus(TN, 1'b0, 1'b0);
        checkOutput("idle_cnt", 64'(cntA), 64'd1);
        checkOutput("idle_st",  64'(dutA.state_q), 64'(ST_IDLE));

        // Clear together with a rising edge: no write, counts zeroed.
        applyStimulus(TA, 1'b1, 1'b1);
        checkOutput("clr_req",  64'(reqA), 64'd0);
        checkOutput("clr_cntA", 64'(cntA), 64'd0);
        checkOutput("clr_cntB", 64'(cntB), 64'd0);
        checkOutput("clr_st",   64'(dutA.state_q), 64'(ST_ARMED));
        applyStimulus(TN, 1'b0, 1'b1);

        // Hold-off of 4 with pulses at relative cycles 0, 2 and 5.
        applyStimulus(TN, 1'b1, 1'b1);
        for (int c = 0; c < 8; c++) begin
            applyStimulus(patC[c] ? TC : TN, 1'b0, 1'b1);
            if (c == 0) begin
                checkOutput("t3_req0",  64'(reqC),  64'd1);
                checkOutput("t3_addr0", 64'(addrC), 64'd0);
                checkOutput("t3_data0", 64'(dataC), 64'd0);
            end
            if (c == 2) begin
                checkOutput("t3_req2", 64'(reqC), 64'd0);
                checkOutput("t3_rej2", 64'(rejC), 64'd1);
            end
            if (c == 5) begin
                checkOutput("t3_req5",  64'(reqC),  64'd1);
                checkOutput("t3_addr5", 64'(addrC), 64'd1);
                checkOutput("t3_data5", 64'(dataC), 64'd5);
            end
        end
        checkOutput("t3_cnt", 64'(cntC), 64'd2);
        checkOutput("t3_rej", 64'(rejC), 64'd1);

        // Four-entry RAM, six pulses: D stops full, E wraps.
        applyStimulus(TN, 1'b1, 1'b1);
        for (int p = 0; p < 6; p++) begin
            applyStimulus(TD | TE, 1'b0, 1'b1);
            checkOutput($sformatf("t4_reqD%0d", p), 64'(reqD), (p < 4) ? 64'd1 : 64'd0);
            if (p < 4) begin
                checkOutput($sformatf("t4_addrD%0d", p), 64'(addrD), 64'(p));
            end
            checkOutput($sformatf("t4_reqE%0d", p),  64'(reqE),  64'd1);
            checkOutput($sformatf("t4_addrE%0d", p), 64'(addrE), 64'(p % 4));
            applyStimulus(TN, 1'b0, 1'b1);
            if (p == 2) begin
                checkOutput("t4_fullD_lo", 64'(fullD), 64'd0);
                checkOutput("t4_wrapE_lo", 64'(wrapE), 64'd0);
            end
            if (p == 3) begin
                checkOutput("t4_fullD_hi", 64'(fullD), 64'd1);
                checkOutput("t4_wrapE_hi", 64'(wrapE), 64'd1);
            end
        end
        checkOutput("t4_cntD",  64'(cntD),  64'd4);
        checkOutput("t4_rejD",  64'(rejD),  64'd2);
        checkOutput("t4_stD",   64'(dutD.state_q), 64'(ST_FULL));
        checkOutput("t4_cntE",  64'(cntE),  64'd6);
        checkOutput("t4_rejE",  64'(rejE),  64'd0);
        checkOutput("t4_wrapD", 64'(wrapD), 64'd0);
        checkOutput("t4_fullE", 64'(fullE), 64'd0);

        // 3-bit counter, nine pulses: stops at 7 and flags saturation.
        applyStimulus(TN, 1'b1, 1'b1);
        for (int p = 0; p < 9; p++) begin
            applyStimulus(TF, 1'b0, 1'b1);
            applyStimulus(TN, 1'b0, 1'b1);
            if (p == 5) begin
                checkOutput("t5_cnt6", 64'(cntF), 64'd6);
                checkOutput("t5_sat6", 64'(satF), 64'd0);
            end
        end
        checkOutput("t5_cnt",  64'(cntF),  64'd7);
        checkOutput("t5_sat",  64'(satF),  64'd1);
        checkOutput("t5_addr", 64'(addrF), 64'd8);
        checkOutput("t5_rej",  64'(rejF),  64'd0);

        // Reset asserted during hold-off: outputs drop without waiting for a clock.
        applyStimulus(TN, 1'b1, 1'b1);
        applyStimulus(TN, 1'b0, 1'b1);
        applyStimulus(TN, 1'b0, 1'b1);
        applyStimulus(TC, 1'b0, 1'b1);
        checkOutput("t6_req_pre",  64'(reqC),  64'd1);
        checkOutput("t6_data_pre", 64'(dataC), 64'd2);
        checkOutput("t6_st_pre",   64'(dutC.state_q), 64'(ST_HOLD));
        trig = TN;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_req",  64'(reqC),  64'd0);
        checkOutput("t6_cnt",  64'(cntC),  64'd0);
        checkOutput("t6_data", 64'(dataC), 64'd0);
        checkOutput("t6_st",   64'(dutC.state_q), 64'(ST_IDLE));
        checkOutput("t6_hcnt", 64'(dutC.hcnt_q),  64'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
